// File: rtl/cgm_switch_ctrl_pkg.sv
// Shared types and constants for the clock-generator-mux switch controller.
// Holds FSM states, select encodings, default window/settle and expected edge-count ranges.
package cgm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_CHECK,
        ST_REPORT
    } cgm_state_t;

    localparam logic [1:0] SEL_CLK0    = 2'd0;
    localparam logic [1:0] SEL_CLK1    = 2'd1;
    localparam logic [1:0] SEL_CLK2    = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

    localparam int DEF_SETTLE_CYC = 64;
    localparam int DEF_WIN_CYC    = 256;

    // Edge counts of clk_out_div (clk_out/8) expected in one default window
    localparam int DEF_EXP0_MIN = 28;
    localparam int DEF_EXP0_MAX = 36;
    localparam int DEF_EXP1_MIN = 7;
    localparam int DEF_EXP1_MAX = 11;
    localparam int DEF_EXP2_MIN = 4;
    localparam int DEF_EXP2_MAX = 7;

    function automatic logic in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/cgm_switch_ctrl_if.sv
// Request/status bundle between software-facing logic and the clock switch controller.
// master = requester, slave = controller.
interface cgm_switch_ctrl_if;

    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [1:0] cgm_sel;
    logic [1:0] cur_sel;
    logic       ack;
    logic       err;
    logic       busy;

    modport master (
        output req_valid, req_sel,
        input  req_ready, cgm_sel, cur_sel, ack, err, busy
    );

    modport slave (
        input  req_valid, req_sel,
        output req_ready, cgm_sel, cur_sel, ack, err, busy
    );

endinterface

// File: rtl/cgm_freq_meter.sv
// Counts synchronized rising edges of clk_out_div over a WIN_CYC-cycle window (saturating).
// done is combinational on the last window cycle; freeze holds window and count in place.
module cgm_freq_meter
    import cgm_pkg::*;
#(
    parameter int WIN_CYC = DEF_WIN_CYC,
    parameter int CNT_W   = $clog2(WIN_CYC) + 1
) (
    input  logic             clk_in0,
    input  logic             rst_clk_n,
    input  logic             clk_out_div,
    input  logic             freeze,
    input  logic             start,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             rise;
    logic             running;
    logic [CNT_W-1:0] win_cnt;

    // Synchronizer and edge-detect run free so the chain stays coherent across a freeze
    always_ff @(posedge clk_in0 or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= clk_out_div;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign done = running && !freeze && (win_cnt == WIN_LAST);

    always_ff @(posedge clk_in0 or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            running <= 1'b0;
            win_cnt <= '0;
            count   <= '0;
        end else if (!freeze) begin
            if (start) begin
                running <= 1'b1;
                win_cnt <= '0;
                count   <= '0;
            end else if (running) begin
                if (rise && (count != '1)) begin
                    count <= count + CNT_W'(1);
                end
                if (win_cnt == WIN_LAST) begin
                    running <= 1'b0;
                    win_cnt <= '0;
                end else begin
                    win_cnt <= win_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cgm_switch_ctrl.sv
// Glitch-free clock switch controller: select, settle, measure clk_out_div, report ack/err.
// Result SETTLE_CYC+WIN_CYC+2 cycles after accept (WIN_CYC+2 same-select); one request in flight.
module cgm_switch_ctrl
    import cgm_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WIN_CYC    = DEF_WIN_CYC,
    parameter int EXP0_MIN   = DEF_EXP0_MIN,
    parameter int EXP0_MAX   = DEF_EXP0_MAX,
    parameter int EXP1_MIN   = DEF_EXP1_MIN,
    parameter int EXP1_MAX   = DEF_EXP1_MAX,
    parameter int EXP2_MIN   = DEF_EXP2_MIN,
    parameter int EXP2_MAX   = DEF_EXP2_MAX
) (
    input  logic             clk_in0,
    input  logic             rst_clk_n,
    input  logic             scan_dc_mode,
    input  logic             clk_out_div,
    cgm_switch_ctrl_if.slave ctl
);

    localparam int CNT_W = $clog2(WIN_CYC) + 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

    cgm_state_t       state_q;
    cgm_state_t       state_d;
    logic [SET_W-1:0] settle_q;
    logic [SET_W-1:0] settle_d;
    logic [1:0]       cgm_sel_q;
    logic [1:0]       cgm_sel_d;
    logic [1:0]       cur_sel_q;
    logic [1:0]       cur_sel_d;
    logic             ack_q;
    logic             ack_d;
    logic             err_q;
    logic             err_d;
    logic             meter_start;
    logic             meter_done;
    logic [CNT_W-1:0] meter_count;
    logic             cnt_ok;
    int               exp_lo;
    int               exp_hi;

    cgm_freq_meter #(
        .WIN_CYC (WIN_CYC),
        .CNT_W   (CNT_W)
    ) u_meter (
        .clk_in0     (clk_in0),
        .rst_clk_n   (rst_clk_n),
        .clk_out_div (clk_out_div),
        .freeze      (scan_dc_mode),
        .start       (meter_start),
        .done        (meter_done),
        .count       (meter_count)
    );

    always_comb begin
        exp_lo = 1;
        exp_hi = 0;
        case (cgm_sel_q)
            SEL_CLK0: begin exp_lo = EXP0_MIN; exp_hi = EXP0_MAX; end
            SEL_CLK1: begin exp_lo = EXP1_MIN; exp_hi = EXP1_MAX; end
            SEL_CLK2: begin exp_lo = EXP2_MIN; exp_hi = EXP2_MAX; end
            default:  ;
        endcase
        cnt_ok = in_range(int'(meter_count), exp_lo, exp_hi);
    end

    // Scan freeze: no transition, no pulse, counters hold
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        cgm_sel_d   = cgm_sel_q;
        cur_sel_d   = cur_sel_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        meter_start = 1'b0;
        if (!scan_dc_mode) begin
            case (state_q)
                ST_IDLE: begin
                    if (ctl.req_valid) begin
                        if (ctl.req_sel == SEL_ILLEGAL) begin
                            err_d = 1'b1;
                        end else if (ctl.req_sel == cgm_sel_q) begin
                            meter_start = 1'b1;
                            state_d     = ST_MEASURE;
                        end else begin
                            cgm_sel_d = ctl.req_sel;
                            settle_d  = SETTLE_LOAD;
                            state_d   = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        meter_start = 1'b1;
                        state_d     = ST_MEASURE;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (meter_done) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cnt_ok) begin
                        ack_d     = 1'b1;
                        cur_sel_d = cgm_sel_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_REPORT;
                end
                ST_REPORT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in0 or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            cgm_sel_q <= SEL_CLK0;
            cur_sel_q <= SEL_CLK0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            cgm_sel_q <= cgm_sel_d;
            cur_sel_q <= cur_sel_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign ctl.req_ready = rst_clk_n && (state_q == ST_IDLE) && !scan_dc_mode;
    assign ctl.cgm_sel   = cgm_sel_q;
    assign ctl.cur_sel   = cur_sel_q;
    assign ctl.ack       = ack_q;
    assign ctl.err       = err_q;
    assign ctl.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/cgm_switch_ctrl.md
CGM_SWITCH_CTRL -- requirements
Module: cgm_switch_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 64, which sets the clk_in0 cycles to wait after cgm_sel changes.
REQ-002 SHALL have parameter WIN_CYC, default 256, which sets the length of the measurement window in clk_in0 cycles.
REQ-003 SHALL have parameters EXP0_MIN/EXP0_MAX, EXP1_MIN/EXP1_MAX and EXP2_MIN/EXP2_MAX, defaults 28/36, 7/11 and 4/7, which set the allowed clk_out_div rising-edge count per source.
REQ-004 clk_in0  input  1  controller clock: always-on fastest source; all logic is in this domain.
REQ-005 rst_clk_n  input  1  asynchronous active-low reset.
REQ-006 scan_dc_mode  input  1  scan freeze; when high the FSM holds and no request is accepted.
REQ-007 req_valid  input  1  switch request valid.
REQ-008 req_sel  input  2  requested source: 0, 1 or 2; 3 is illegal.
REQ-009 req_ready  output  1  request accepted when req_valid and req_ready are both high on a clk_in0 rising edge.
REQ-010 clk_out_div  input  1  clk_out divided by 8, asynchronous to clk_in0.
REQ-011 cgm_sel  output  2  select driven to the glitch-free clock switch.
REQ-012 cur_sel  output  2  last source verified good.
REQ-013 ack  output  1  one-cycle pulse: switch verified.
REQ-014 err  output  1  one-cycle pulse: illegal select or measurement out of range.
REQ-015 busy  output  1  FSM not in IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, SETTLE, MEASURE, CHECK and REPORT.
REQ-017 req_ready SHALL equal (state==IDLE) and not scan_dc_mode.
REQ-018 On an accepted request with req_sel<=2: cgm_sel<=req_sel on the next edge, the settle counter loads SETTLE_CYC-1, and state goes to SETTLE.
REQ-019 On an accepted request with req_sel==3: err SHALL pulse on the next cycle, cgm_sel and cur_sel SHALL be unchanged, and state SHALL stay IDLE.
REQ-020 On an accepted request with req_sel==cgm_sel: SETTLE SHALL be skipped and state goes directly to MEASURE.
REQ-021 SETTLE SHALL decrement the counter each cycle and move to MEASURE when the counter is 0 (exactly SETTLE_CYC cycles).
REQ-022 clk_out_div SHALL pass through a 2-flop synchronizer plus an edge-detect flop.
REQ-023 A rising edge is the synchronized value being 1 with its previous sample 0.
REQ-024 MEASURE SHALL count rising edges for exactly WIN_CYC cycles.
REQ-025 The edge counter SHALL be $clog2(WIN_CYC)+1 bits wide and SHALL saturate at all-ones without wrapping.
REQ-026 The edge counter and the window counter SHALL clear on entry to MEASURE.
REQ-027 CHECK lasts one cycle and SHALL compare the edge count against the EXPn_MIN..EXPn_MAX range (inclusive) for n=cgm_sel.
REQ-028 If the count is in range, ack SHALL pulse and cur_sel<=cgm_sel.
REQ-029 If the count is out of range, err SHALL pulse, cur_sel SHALL be unchanged, and cgm_sel SHALL remain at the new value so software can retry.
REQ-030 REPORT lasts one cycle and returns to IDLE.
REQ-031 Latency from acceptance to ack/err SHALL be SETTLE_CYC+WIN_CYC+2 cycles for a normal switch and WIN_CYC+2 cycles for a same-select request.
REQ-032 ack and err SHALL never be high in the same cycle.
REQ-033 While scan_dc_mode is high, all counters and the state SHALL freeze, req_ready=0, and cgm_sel SHALL be held.
REQ-034 When scan_dc_mode returns low, operation SHALL resume from the frozen point.
REQ-035 A req_valid arriving while busy SHALL be ignored (not queued).

Reset
REQ-036 On rst_clk_n low, asynchronously: state=IDLE, cgm_sel=0, cur_sel=0, ack=0, err=0, busy=0, all counters and synchronizer flops cleared.
REQ-037 req_ready SHALL be 0 while reset is asserted.
REQ-038 Reset asserted mid-SETTLE or mid-MEASURE SHALL abort the operation with no ack/err pulse; after release cgm_sel=0.
REQ-039 Reset deassertion needs no synchronizer here; it is synchronized upstream.

Structure
REQ-040 A shared package cgm_pkg SHALL hold the FSM state enum, the select encodings SEL_CLK0/1/2 and the illegal value 3.
REQ-041 cgm_pkg SHALL hold the default window, settle and expected-range constants.
REQ-042 The edge-counting monitor (synchronizer, edge detect, window counter, saturating count) SHALL be one sub-module, cgm_freq_meter, with start, done and count ports.
REQ-043 Controller plus meter SHALL fit within 150-300 lines of RTL.

Verification
REQ-044 Reset, then request sel=2 with clk_in0 period 40 ns and clk_out_div = clk_in2/8 (1760 ns period) -> cgm_sel=2 at acceptance+1; ack at acceptance+322 cycles; cur_sel=2.
REQ-045 Request sel=3 -> err pulse at acceptance+1; cgm_sel and cur_sel unchanged; req_ready high again the next cycle.
REQ-046 Request sel=1 with clk_out_div held at 0 (dead clock) -> err at acceptance+322; cgm_sel=1; cur_sel keeps its old value.
REQ-047 Request sel=0 while cgm_sel=0 -> no SETTLE phase; ack at acceptance+258.
REQ-048 scan_dc_mode pulsed high for 100 cycles mid-MEASURE -> ack delayed by exactly 100 cycles and count unchanged.
REQ-049 rst_clk_n low mid-SETTLE -> no ack/err; after release cgm_sel=0 and busy=0.
REQ-050 A second req_valid while busy -> ignored; exactly one ack.
